// File: rtl/cpu_pipelined_mul_unit.sv
// Stallable multiply pipeline: the product is formed at issue and carried through
// STAGES registers; a non-accepted writeback result freezes every stage.
module cpu_pipelined_mul_unit #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int STAGES   = 5,
    localparam int RD_W    = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [RD_W-1:0]     in_rd_id,
    input  logic                in_wb,
    input  logic [WIDTH-1:0]    in_ra_data,
    input  logic [WIDTH-1:0]    in_rb_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RD_W-1:0]     out_rd_id,
    output logic [WIDTH-1:0]    out_data,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                busy
);
    localparam int LAST = STAGES - 1;

    // A is sign-extended for MULH/MULHSU, B only for MULH; the signed multiply of the
    // extended operands is exact for all four modes.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [1:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH:0]     ae;
        logic signed [WIDTH:0]     be;
        logic signed [2*WIDTH+1:0] p;
        ae = {((op == 2'd1) || (op == 2'd2)) & a[WIDTH-1], a};
        be = {(op == 2'd1) & b[WIDTH-1], b};
        p  = $signed({{(WIDTH+1){ae[WIDTH]}}, ae}) * $signed({{(WIDTH+1){be[WIDTH]}}, be});
        return p[2*WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] select_half(input logic [1:0] op,
                                                     input logic [2*WIDTH-1:0] prod);
        return (op == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    endfunction

    logic [STAGES-1:0]  vld_p;
    logic [STAGES-1:0]  wb_p;
    logic [1:0]         op_p   [STAGES];
    logic [RD_W-1:0]    rd_p   [STAGES];
    logic [2*WIDTH-1:0] prod_p [STAGES];
    logic               stall;

    assign out_valid = vld_p[LAST] & wb_p[LAST];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign busy      = |vld_p;
    // Gating with out_valid keeps the data registers reset-free while outputs read 0.
    assign out_rd_id = out_valid ? rd_p[LAST] : '0;
    assign out_data  = out_valid ? select_half(op_p[LAST], prod_p[LAST]) : '0;

    always_comb begin
        pending_mask = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (vld_p[k] && wb_p[k]) pending_mask[rd_p[k]] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
        end else if (flush) begin
            vld_p <= '0;
        end else if (!stall) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    // stage 0 captures the full product; later stages only shift
    always_ff @(posedge clock) begin
        if (!stall) begin
            wb_p[0]   <= in_wb;
            op_p[0]   <= in_op;
            rd_p[0]   <= in_rd_id;
            prod_p[0] <= mul_full(in_op, in_ra_data, in_rb_data);
            for (int k = 1; k < STAGES; k++) begin
                wb_p[k]   <= wb_p[k-1];
                op_p[k]   <= op_p[k-1];
                rd_p[k]   <= rd_p[k-1];
                prod_p[k] <= prod_p[k-1];
            end
        end
    end
endmodule

// File: tb/tb_cpu_pipelined_mul_unit.sv
// Directed bench for cpu_pipelined_mul_unit at WIDTH=32, NUM_REGS=16, STAGES=5.
module tb_cpu_pipelined_mul_unit;
    localparam int WIDTH    = 32;
    localparam int NUM_REGS = 16;
    localparam int STAGES   = 5;
    localparam int RD_W     = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic [RD_W-1:0]     in_rd_id;
    logic                in_wb;
    logic [WIDTH-1:0]    in_ra_data;
    logic [WIDTH-1:0]    in_rb_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [RD_W-1:0]     out_rd_id;
    logic [WIDTH-1:0]    out_data;
    logic [NUM_REGS-1:0] pending_mask;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    cpu_pipelined_mul_unit #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .STAGES(STAGES)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd_id(in_rd_id),
        .in_wb(in_wb), .in_ra_data(in_ra_data), .in_rb_data(in_rb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_id(out_rd_id), .out_data(out_data),
        .pending_mask(pending_mask), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next cycle and return the issue port to idle.
    task automatic next_cycle();
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [RD_W-1:0] rd, input logic wb,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid   = 1'b1;
        in_op      = op;
        in_rd_id   = rd;
        in_wb      = wb;
        in_ra_data = a;
        in_rb_data = b;
        #1;
    endtask

    logic [WIDTH-1:0] mode_exp [4];

    initial begin
        mode_exp[0] = 32'hFFFF_FFFE;
        mode_exp[1] = 32'hFFFF_FFFF;
        mode_exp[2] = 32'hFFFF_FFFF;
        mode_exp[3] = 32'h0000_0001;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_rd_id = '0;
        in_wb = 1'b0; in_ra_data = '0; in_rb_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending_mask, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_rd", out_rd_id, 0);
        reset = 1'b0;

        // basic latency and pending tracking
        next_cycle();
        send(2'd0, 4'd3, 1'b1, 32'd7, 32'd6);
        check("lat_in_ready", in_ready, 1);
        for (int t = 1; t <= 6; t++) begin
            next_cycle();
            check("lat_out_valid", out_valid, (t == 5));
            check("lat_pend3", pending_mask[3], (t <= 5));
            if (t == 5) begin
                check("lat_data", out_data, 42);
                check("lat_rd", out_rd_id, 3);
            end
        end

        // result modes
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            send(i[1:0], 4'(i + 1), 1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
        end
        for (int t = 4; t <= 8; t++) begin
            next_cycle();
            if (t >= 5) begin
                check("mode_valid", out_valid, 1);
                check("mode_data", out_data, mode_exp[t-5]);
                check("mode_rd", out_rd_id, t - 4);
            end
        end

        // back-to-back issues with back-pressure
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            send(2'd0, 4'(i), 1'b1, 32'(i), 32'd10);
        end
        for (int t = 5; t <= 8; t++) begin
            next_cycle();
            out_ready = 1'b0;
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 10);
            check("bp_rd", out_rd_id, 1);
        end
        for (int t = 9; t <= 13; t++) begin
            next_cycle();
            out_ready = 1'b1;
            #1;
            check("bp_drain_valid", out_valid, 1);
            check("bp_drain_data", out_data, 10 * (t - 8));
            check("bp_drain_rd", out_rd_id, t - 8);
        end
        next_cycle();
        check("bp_empty_valid", out_valid, 0);
        check("bp_empty_busy", busy, 0);

        // wb=0 entry retires silently ahead of a stalled wb=1 entry
        out_ready = 1'b0;
        next_cycle();
        send(2'd0, 4'd2, 1'b0, 32'd5, 32'd5);
        next_cycle();
        send(2'd0, 4'd4, 1'b1, 32'd3, 32'd3);
        check("nowb_pend_t1", pending_mask, 0);
        for (int t = 2; t <= 7; t++) begin
            next_cycle();
            check("nowb_pend", pending_mask, 16'h0010);
            check("nowb_valid", out_valid, (t >= 6));
            check("nowb_in_ready", in_ready, (t < 6));
            if (t >= 6) begin
                check("nowb_data", out_data, 9);
                check("nowb_rd", out_rd_id, 4);
            end
        end
        next_cycle();
        out_ready = 1'b1;
        #1;
        check("nowb_accept", out_valid, 1);
        next_cycle();
        check("nowb_done_valid", out_valid, 0);
        check("nowb_done_busy", busy, 0);

        // flush with concurrent issue
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            send(2'd0, 4'(i + 1), 1'b1, 32'(i), 32'(i));
        end
        next_cycle();
        send(2'd0, 4'd7, 1'b1, 32'd1, 32'd1);
        flush = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 1);
        check("fl_busy_before", busy, 1);
        next_cycle();
        check("fl_busy", busy, 0);
        check("fl_pending", pending_mask, 0);
        check("fl_valid", out_valid, 0);
        for (int k = 1; k <= STAGES; k++) begin
            next_cycle();
            check("fl_valid_after", out_valid, 0);
        end

        // asynchronous reset mid-flight
        out_ready = 1'b0;
        next_cycle();
        send(2'd0, 4'd9, 1'b1, 32'd5, 32'd5);
        for (int t = 1; t <= 5; t++) next_cycle();
        check("ar_valid_before", out_valid, 1);
        check("ar_data_before", out_data, 25);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_pending", pending_mask, 0);
        #2;
        reset = 1'b0;
        next_cycle();
        check("ar_in_ready", in_ready, 1);
        check("ar_out_valid", out_valid, 0);
        check("ar_out_data", out_data, 0);
        check("ar_out_rd", out_rd_id, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_pipelined_mul_unit.md
Name: cpu_pipelined_mul_unit

Overview:
Parametrised, stallable multiply pipeline for the execute stage, the successor to the fixed 5-stage multiplier. Accepts one multiply per cycle over a valid/ready issue port and supports low, signed-high, signed×unsigned-high and unsigned-high result modes. Delivers results through a dedicated valid/ready writeback port with back-pressure, and supports flush of in-flight operations. Exports a pending-destination mask that the issue logic uses for RAW hazard detection.

Parameters:
WIDTH, 32, operand and result width in bits
NUM_REGS, 16, architectural register count; RD_W = $clog2(NUM_REGS)
STAGES, 5, pipeline depth; minimum 1; also the unstalled latency in cycles

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  issue request valid
in_ready  out  1  unit can accept an issue this cycle
in_op  in  2  0=MUL low, 1=MULH s×s, 2=MULHSU s×u, 3=MULHU u×u
in_rd_id  in  RD_W  destination register
in_wb  in  1  1 = result must be written back
in_ra_data  in  WIDTH  operand A (the signed operand for MULHSU)
in_rb_data  in  WIDTH  operand B
flush  in  1  kill all in-flight operations
out_valid  out  1  writeback result valid
out_ready  in  1  writeback port accepts result
out_rd_id  out  RD_W  destination register of result
out_data  out  WIDTH  result
pending_mask  out  NUM_REGS  bit r set while an in-flight wb=1 op targets r
busy  out  1  any stage holds a valid entry

Behaviour:
- Each stage register holds: valid, wb, op, rd_id, and the 2*WIDTH product, or operands until the multiply stage. Product bit placement and the high/low select are free within the STAGES budget.
- Issue handshake: an issue occurs when in_valid & in_ready. in_ready = !stall. stall = last-stage valid & wb & !out_ready.
- Stall freezes all stages globally; there is no bubble collapse. When not stalled, every stage advances each cycle and stage 0 loads the issue, or a bubble if no issue occurs.
- out_valid = last-stage valid & wb. out_rd_id and out_data come from the last stage. While out_valid is high and out_ready is low, out_valid, out_rd_id and out_data hold stable.
- A wb=0 entry retires from the last stage without a handshake and never asserts out_valid.
- Latency: an op issued at cycle t presents out_valid at t+STAGES if there is no stall. Throughput is 1 op/cycle.
- Arithmetic: MUL = low WIDTH bits of the product. MULH = high WIDTH bits of signed(A)×signed(B). MULHSU = high WIDTH bits of signed(A)×unsigned(B). MULHU = high WIDTH bits of unsigned(A)×unsigned(B). The operation is exact over the 2*WIDTH result with no saturation.
- pending_mask: combinational OR over all valid, wb=1 stages of onehot(rd_id). This includes the last stage while it is waiting for out_ready. Duplicate targets are allowed.
- busy = OR of all stage valid bits.
- Flush is synchronous and highest priority. At the clock edge, all valid bits clear and a concurrent issue is discarded; in_ready is not deasserted for it. A result with out_valid & out_ready in the flush cycle counts as written back. The cycle after a flush: out_valid=0, pending_mask=0, busy=0.
- Reset: all valid bits 0. Outputs: out_valid=0, out_rd_id=0, out_data=0, pending_mask=0, busy=0, in_ready=1. Reset mid-operation discards all entries immediately, asynchronously.
- STAGES=1: the product is registered once, and stall/handshake rules are unchanged.

Test Plan:
- WIDTH=32, STAGES=5: issue MUL 7×6 rd=3 wb=1 at t0, out_ready=1 -> out_valid at t5, out_data=42, out_rd_id=3; pending_mask bit3 set t1..t5, clear at t6.
- Mode check with A=0xFFFFFFFF, B=0x00000002 -> MUL=0xFFFFFFFE, MULH=0xFFFFFFFF, MULHSU=0xFFFFFFFF, MULHU=0x00000001.
- Back-to-back 5 issues (rd=1..5, A=rd, B=10) with out_ready low t5..t8 -> in_ready=0 t5..t8, out_data=10 held stable. Results then arrive in order 10,20,30,40,50 with no loss or duplication.
- Issue wb=0 rd=2 then wb=1 rd=4 (3×3), out_ready=0 -> the wb=0 entry never raises out_valid or stalls; pending_mask shows only bit4; out_data=9.
- Three ops in flight, flush asserted together with a new issue -> next cycle busy=0, pending_mask=0, out_valid stays 0 for the following STAGES cycles.
- Assert reset mid-flight with out_valid=1 -> out_valid, busy, pending_mask drop to 0 without a clock edge; in_ready=1 after release.
